// File: rtl/conv_operand_buffer.sv
// Run-time loadable operand store: a serial load of an input tile then a filter,
// presented as flat buses plus a selectable K_DIM x K_DIM input window.
module conv_operand_buffer #(
  parameter  int DATA_W  = 8,
  parameter  int IN_DIM  = 4,
  parameter  int K_DIM   = 3,
  localparam int N_IN    = IN_DIM * IN_DIM,
  localparam int N_F     = K_DIM * K_DIM,
  localparam int OUT_DIM = IN_DIM - K_DIM + 1,
  localparam int CNT_W   = $clog2(N_IN + N_F + 1),
  localparam int POS_W   = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   load_valid,
  input  logic [DATA_W-1:0]      load_data,
  output logic                   load_ready,
  input  logic                   release_tile,
  output logic                   busy,
  output logic                   data_valid,
  output logic [CNT_W-1:0]       load_count,
  output logic [N_IN*DATA_W-1:0] input_data,
  output logic [N_F*DATA_W-1:0]  filter_data,
  input  logic [POS_W-1:0]       win_row,
  input  logic [POS_W-1:0]       win_col,
  output logic [N_F*DATA_W-1:0]  window_data
);

  typedef enum logic [1:0] {IDLE, LOAD_IN, LOAD_F, FULL} state_t;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] in_mem [N_IN];
  logic [DATA_W-1:0] f_mem  [N_F];
  logic              accept;

  // Handshake outputs decode from the registered state only.
  assign load_ready = (state == LOAD_IN) || (state == LOAD_F);
  assign busy       = load_ready;
  assign data_valid = (state == FULL);
  assign accept     = load_valid && load_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD_IN;
      LOAD_IN: if (accept && load_count == CNT_W'(N_IN - 1)) state_next = LOAD_F;
      LOAD_F:  if (accept && load_count == CNT_W'(N_IN + N_F - 1)) state_next = FULL;
      FULL:    if (release_tile) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_count <= '0;
      for (int i = 0; i < N_IN; i++) in_mem[i] <= '0;
      for (int j = 0; j < N_F; j++)  f_mem[j]  <= '0;
    end else if (state == IDLE && start) begin
      load_count <= '0;
    end else if (accept) begin
      load_count <= load_count + CNT_W'(1);
      for (int i = 0; i < N_IN; i++)
        if (state == LOAD_IN && load_count == CNT_W'(i)) in_mem[i] <= load_data;
      for (int j = 0; j < N_F; j++)
        if (state == LOAD_F && load_count == CNT_W'(N_IN + j)) f_mem[j] <= load_data;
    end
  end

  always_comb begin
    input_data = '0;
    for (int i = 0; i < N_IN; i++) input_data[i*DATA_W +: DATA_W] = in_mem[i];
  end

  always_comb begin
    filter_data = '0;
    for (int j = 0; j < N_F; j++) filter_data[j*DATA_W +: DATA_W] = f_mem[j];
  end

  // Each window element is found by matching the tile index, so every array
  // index stays constant and an off-tile origin simply yields zero.
  always_comb begin
    window_data = '0;
    if (int'(win_row) < OUT_DIM && int'(win_col) < OUT_DIM) begin
      for (int r = 0; r < K_DIM; r++)
        for (int c = 0; c < K_DIM; c++)
          for (int i = 0; i < N_IN; i++)
            if (i == (int'(win_row) + r) * IN_DIM + int'(win_col) + c)
              window_data[(r*K_DIM + c)*DATA_W +: DATA_W] = in_mem[i];
    end
  end

endmodule

// File: tb/tb_conv_operand_buffer.sv
// Randomized self-checking bench for conv_operand_buffer against a tile/filter
// reference model, with a second wide instance for the 16-bit, 5x5 case.
module tb_conv_operand_buffer;

  localparam int N_IN_A  = 16;
  localparam int N_F_A   = 9;
  localparam int TOTAL_A = N_IN_A + N_F_A;
  localparam int N_IN_B  = 25;
  localparam int N_F_B   = 9;
  localparam int TOTAL_B = N_IN_B + N_F_B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start, load_valid, release_tile, load_ready, busy, data_valid;
  logic [7:0]   load_data;
  logic [4:0]   load_count;
  logic [127:0] input_data;
  logic [71:0]  filter_data, window_data;
  logic [0:0]   win_row, win_col;

  logic         b_start, b_load_valid, b_release, b_load_ready, b_busy, b_data_valid;
  logic [15:0]  b_load_data;
  logic [5:0]   b_load_count;
  logic [399:0] b_input_data;
  logic [143:0] b_filter_data, b_window_data;
  logic [1:0]   b_win_row, b_win_col;

  conv_operand_buffer #(.DATA_W(8), .IN_DIM(4), .K_DIM(3)) u_dut (
    .clk(clk), .rst(rst), .start(start), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .release_tile(release_tile),
    .busy(busy), .data_valid(data_valid), .load_count(load_count),
    .input_data(input_data), .filter_data(filter_data),
    .win_row(win_row), .win_col(win_col), .window_data(window_data)
  );

  conv_operand_buffer #(.DATA_W(16), .IN_DIM(5), .K_DIM(3)) u_dut_wide (
    .clk(clk), .rst(rst), .start(b_start), .load_valid(b_load_valid),
    .load_data(b_load_data), .load_ready(b_load_ready), .release_tile(b_release),
    .busy(b_busy), .data_valid(b_data_valid), .load_count(b_load_count),
    .input_data(b_input_data), .filter_data(b_filter_data),
    .win_row(b_win_row), .win_col(b_win_col), .window_data(b_window_data)
  );

  int checks   = 0;
  int failures = 0;
  int expIn[$];
  int expF[$];

  task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] packTile(input int tile[$], input int dw);
    logic [511:0] v = '0;
    foreach (tile[i]) v |= 512'(tile[i]) << (i * dw);
    return v;
  endfunction

  // Window of the model tile straight from the sliding-window definition.
  function automatic logic [511:0] expWindow(input int tile[$], input int inDim, input int kDim,
                                             input int dw, input int r0, input int c0);
    logic [511:0] v = '0;
    if (r0 > inDim - kDim || c0 > inDim - kDim) return v;
    for (int r = 0; r < kDim; r++)
      for (int c = 0; c < kDim; c++)
        v |= 512'(tile[(r0 + r) * inDim + c0 + c]) << ((r * kDim + c) * dw);
    return v;
  endfunction

  task automatic clearModel();
    expIn = {};
    expF  = {};
    for (int i = 0; i < N_IN_A; i++) expIn.push_back(0);
    for (int j = 0; j < N_F_A; j++)  expF.push_back(0);
  endtask

  task automatic checkReset();
    checkOutput("rst_input", input_data, 0);
    checkOutput("rst_filter", filter_data, 0);
    checkOutput("rst_window", window_data, 0);
    checkOutput("rst_count", load_count, 0);
    checkOutput("rst_ready", load_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_valid", data_valid, 0);
    checkOutput("rst_b_valid", b_data_valid, 0);
    checkOutput("rst_b_input", b_input_data, 0);
  endtask

  // Start a load and stream vals until stopAfter elements are accepted.
  // mode 0: valid always high, 1: valid every other cycle, 2: random valid.
  task automatic applyStimulus(input int vals[$], input int mode, input int stopAfter);
    int accepted = 0;
    int cyc = 0;
    bit v;
    start = 1'b1;
    release_tile = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0;
    release_tile = 1'b0;
    checkOutput("start_count", load_count, 0);
    checkOutput("start_ready", load_ready, 1);
    checkOutput("start_busy", busy, 1);
    while (accepted < stopAfter && cyc < 1000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      load_valid = v;
      load_data  = 8'(vals[accepted]);
      @(negedge clk);
      cyc++;
      if (v) begin
        if (accepted < N_IN_A) expIn[accepted] = vals[accepted];
        else                   expF[accepted - N_IN_A] = vals[accepted];
        accepted++;
      end
      checkOutput("load_count", load_count, accepted);
      checkOutput("valid_during_load", data_valid, accepted == TOTAL_A);
      checkOutput("ready_during_load", load_ready, accepted < TOTAL_A);
    end
    load_valid = 1'b0;
    if (accepted < stopAfter) checkOutput("load_timeout", accepted, stopAfter);
  endtask

  task automatic checkFull();
    checkOutput("full_valid", data_valid, 1);
    checkOutput("full_busy", busy, 0);
    checkOutput("full_ready", load_ready, 0);
    checkOutput("full_count", load_count, TOTAL_A);
    checkOutput("full_input", input_data, packTile(expIn, 8));
    checkOutput("full_filter", filter_data, packTile(expF, 8));
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        win_row = 1'(r);
        win_col = 1'(c);
        #1;
        checkOutput($sformatf("window_%0d_%0d", r, c), window_data, expWindow(expIn, 4, 3, 8, r, c));
      end
    win_row = 1'b0;
    win_col = 1'b0;
  endtask

  task automatic releaseTile();
    release_tile = 1'b1;
    start = 1'b1;
    @(negedge clk);
    release_tile = 1'b0;
    start = 1'b0;
    checkOutput("rel_valid", data_valid, 0);
    checkOutput("rel_busy", busy, 0);
    checkOutput("rel_input_kept", input_data, packTile(expIn, 8));
    checkOutput("rel_count_kept", load_count, TOTAL_A);
  endtask

  initial begin
    int stream[$];
    int rnd[$];
    int w00[$];
    int w11[$];
    int bIn[$];
    int bF[$];
    int bVals[$];
    int dot;

    start = 0; load_valid = 0; load_data = 0; release_tile = 0; win_row = 0; win_col = 0;
    b_start = 0; b_load_valid = 0; b_load_data = 0; b_release = 0; b_win_row = 0; b_win_col = 0;
    clearModel();
    #2 rst = 1'b0;
    #10;
    checkReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    stream = {9,8,2,6,0,4,1,6,4,10,1,1,2,2,9,9,3,2,0,2,0,1,3,1,1};
    applyStimulus(stream, 0, TOTAL_A);
    checkFull();
    checkOutput("input_el9", input_data[9*8 +: 8], 10);
    checkOutput("filter_el0", filter_data[7:0], 3);
    w00 = {9,8,2,0,4,1,4,10,1};
    w11 = {4,1,6,10,1,1,2,9,9};
    win_row = 1'b0; win_col = 1'b0; #1;
    checkOutput("win00_const", window_data, packTile(w00, 8));
    dot = 0;
    for (int i = 0; i < 9; i++)
      dot += int'(window_data[i*8 +: 8]) * int'(filter_data[i*8 +: 8]);
    checkOutput("dot_product", dot, 67);
    win_row = 1'b1; win_col = 1'b1; #1;
    checkOutput("win11_const", window_data, packTile(w11, 8));
    win_row = 1'b0; win_col = 1'b0;

    @(negedge clk);
    releaseTile();
    applyStimulus(stream, 1, TOTAL_A);
    checkFull();
    checkOutput("toggle_same_input", input_data, packTile(stream[0:15], 8));

    releaseTile();
    rnd = {};
    for (int i = 0; i < TOTAL_A; i++) rnd.push_back(int'($urandom_range(0, 255)));
    applyStimulus(rnd, 2, TOTAL_A);
    checkFull();

    releaseTile();
    rnd = {};
    for (int i = 0; i < TOTAL_A; i++) rnd.push_back(int'($urandom_range(0, 255)));
    applyStimulus(rnd, 2, 10);
    rst = 1'b0;
    #1;
    clearModel();
    checkReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rnd = {};
    for (int i = 0; i < TOTAL_A; i++) rnd.push_back(int'($urandom_range(0, 255)));
    applyStimulus(rnd, 0, TOTAL_A);
    checkFull();

    bVals = {};
    bIn = {};
    bF = {};
    for (int i = 0; i < TOTAL_B; i++) bVals.push_back(int'($urandom_range(0, 65535)));
    bVals[24] = 'hBEEF;
    for (int i = 0; i < N_IN_B; i++) bIn.push_back(bVals[i]);
    for (int j = 0; j < N_F_B; j++)  bF.push_back(bVals[N_IN_B + j]);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    checkOutput("b_start_ready", b_load_ready, 1);
    for (int i = 0; i < TOTAL_B; i++) begin
      b_load_valid = 1'b1;
      b_load_data  = 16'(bVals[i]);
      @(negedge clk);
    end
    b_load_valid = 1'b0;
    checkOutput("b_valid", b_data_valid, 1);
    checkOutput("b_busy", b_busy, 0);
    checkOutput("b_count", b_load_count, TOTAL_B);
    checkOutput("b_input", b_input_data, packTile(bIn, 16));
    checkOutput("b_filter", b_filter_data, packTile(bF, 16));
    b_win_row = 2'd2; b_win_col = 2'd2; #1;
    checkOutput("b_win22_el8", b_window_data[8*16 +: 16], 16'hBEEF);
    checkOutput("b_win22", b_window_data, expWindow(bIn, 5, 3, 16, 2, 2));
    b_win_row = 2'd1; b_win_col = 2'd0; #1;
    checkOutput("b_win10", b_window_data, expWindow(bIn, 5, 3, 16, 1, 0));
    b_win_row = 2'd3; b_win_col = 2'd0; #1;
    checkOutput("b_win_row_oor", b_window_data, 0);
    b_win_row = 2'd0; b_win_col = 2'd3; #1;
    checkOutput("b_win_col_oor", b_window_data, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
